// File: rtl/spike_event_fifo.sv
// Spike event capture: rising-edge detect on spike_in, timestamp + membrane tag,
// small circular FIFO with valid/ready drain and sticky overflow / drop counter.
module spike_event_fifo #(
  parameter int unsigned TS_WIDTH = 8,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spike_in,
  input  logic [7:0]                v_in,
  input  logic                      ev_ready,
  input  logic                      clr_ovf,
  output logic                      ev_valid,
  output logic [TS_WIDTH-1:0]       ev_ts,
  output logic [7:0]                ev_v,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [7:0]                drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = TS_WIDTH + 8;

  logic [TS_WIDTH-1:0] r_ts;
  logic                r_spike_d;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [EW-1:0]       r_mem [DEPTH];
  logic                r_overflow;
  logic [7:0]          r_drop_count;

  logic                w_event;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [EW-1:0]       w_head;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_event = spike_in & ~r_spike_d;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = ~w_empty & ev_ready;
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts      <= '0;
      r_spike_d <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_ts      <= r_ts + TS_WIDTH'(1);
      r_spike_d <= spike_in;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_ts, v_in};
  end

  // A drop in the same cycle as clr_ovf wins and restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf)
        r_drop_count <= 8'd1;
      else if (r_drop_count != 8'hFF)
        r_drop_count <= r_drop_count + 8'd1;
    end else if (clr_ovf) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign ev_valid   = ~w_empty;
  assign ev_ts      = w_head[EW-1:8];
  assign ev_v       = w_head[7:0];
  assign level      = r_wr_ptr - r_rd_ptr;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_spike_event_fifo.sv
// Bench for spike_event_fifo: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor.
module tb_spike_event_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       spike_in;
  logic [7:0] v_in;
  logic       ev_ready;
  logic       clr_ovf;
  logic       ev_valid;
  logic [7:0] ev_ts;
  logic [7:0] ev_v;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] drop_count;

  spike_event_fifo #(.TS_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .v_in(v_in),
    .ev_ready(ev_ready), .clr_ovf(clr_ovf), .ev_valid(ev_valid),
    .ev_ts(ev_ts), .ev_v(ev_v), .level(level), .overflow(overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ts;
    logic [7:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         m_level;
  int         m_drop;
  logic       m_ovf;
  logic       m_prev;
  logic [7:0] m_ts;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Reference model: occupancy count plus queue of accepted events in arrival order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_level = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
      m_prev  = 1'b0;
      m_ts    = 8'd0;
    end else begin
      automatic logic ev   = spike_in && !m_prev;
      automatic logic pop  = (m_level > 0) && ev_ready;
      automatic logic push = ev && ((m_level < DEPTH) || pop);
      automatic logic drop = ev && !push;
      if (push) exp_q.push_back('{ts: m_ts, v: v_in});
      m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
      if (drop) begin
        m_ovf  = 1'b1;
        m_drop = clr_ovf ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      m_prev = spike_in;
      m_ts   = m_ts + 8'd1;
    end
  end

  // Monitor: head data must match the oldest expected event; retire it on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ev_valid", 32'(ev_valid), 32'(m_level != 0));
      chk("level", 32'(level), 32'(m_level));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      if (m_level != 0) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 32'(exp_q.size()), 32'(1));
        end else begin
          chk("ev_ts", 32'(ev_ts), 32'(exp_q[0].ts));
          chk("ev_v", 32'(ev_v), 32'(exp_q[0].v));
          if (ev_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic sp, input logic [7:0] v, input logic rdy, input logic clr);
    spike_in = sp;
    v_in     = v;
    ev_ready = rdy;
    clr_ovf  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  initial begin
    spike_in = 1'b0;
    v_in     = 8'd0;
    ev_ready = 1'b0;
    clr_ovf  = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ev_valid), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_drops", 32'(drop_count), 32'(0));
    rst_n = 1'b1;

    // Long pulse starting at ts=5 gives a single event.
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd50, 1'b0, 1'b0);
    chk("t1_valid", 32'(ev_valid), 32'(1));
    chk("t1_ts", 32'(ev_ts), 32'(5));
    chk("t1_v", 32'(ev_v), 32'(50));
    chk("t1_level", 32'(level), 32'(1));
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t1_empty", 32'(level), 32'(0));

    // Five spikes into a stalled FIFO: one drop.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'(10 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
    end
    chk("t2_level", 32'(level), 32'(4));
    chk("t2_overflow", 32'(overflow), 32'(1));
    chk("t2_drops", 32'(drop_count), 32'(1));
    drain(4);
    chk("t2_drained", 32'(level), 32'(0));

    // Push coincident with pop while full is accepted.
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("t3_clr_ovf", 32'(overflow), 32'(0));
    chk("t3_clr_drops", 32'(drop_count), 32'(0));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(20 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
    end
    cyc(1'b1, 8'd99, 1'b1, 1'b0);
    chk("t3_level_full", 32'(level), 32'(4));
    chk("t3_no_drop", 32'(drop_count), 32'(0));
    chk("t3_no_ovf", 32'(overflow), 32'(0));
    drain(4);
    chk("t3_drained", 32'(level), 32'(0));

    // Timestamp wrap with a negative membrane value.
    for (int i = 0; i < 300 && m_ts != 8'd255; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t4_reach_255", 32'(m_ts), 32'(255));
    cyc(1'b1, 8'hEC, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEC, 1'b0, 1'b0);
    chk("t4_level", 32'(level), 32'(2));
    chk("t4_ts_head", 32'(ev_ts), 32'(255));
    chk("t4_v_head", 32'(ev_v), 32'(8'hEC));
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    chk("t4_ts_wrap", 32'(ev_ts), 32'(1));
    chk("t4_v_wrap", 32'(ev_v), 32'(8'hEC));
    drain(2);

    // Saturating drop counter and clear behaviour.
    for (int i = 0; i < 304; i++) begin
      cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
    end
    chk("t5_sat", 32'(drop_count), 32'(255));
    chk("t5_ovf", 32'(overflow), 32'(1));
    cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("t5_clr_drops", 32'(drop_count), 32'(0));
    chk("t5_clr_ovf", 32'(overflow), 32'(0));
    cyc(1'b1, 8'd3, 1'b0, 1'b1);
    chk("t5_clr_vs_drop_cnt", 32'(drop_count), 32'(1));
    chk("t5_clr_vs_drop_ovf", 32'(overflow), 32'(1));
    drain(4);

    // Asynchronous reset with three events queued.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'(40 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
    end
    chk("t6_pre_level", 32'(level), 32'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(ev_valid), 32'(0));
    chk("t6_async_level", 32'(level), 32'(0));
    spike_in = 1'b1;
    v_in     = 8'd77;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 8'd77, 1'b0, 1'b0);
    chk("t6_release_level", 32'(level), 32'(1));
    chk("t6_release_ts", 32'(ev_ts), 32'(0));
    chk("t6_release_v", 32'(ev_v), 32'(77));
    drain(2);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 9) < 4), 8'($urandom), 1'($urandom_range(0, 9) < 5),
          1'($urandom_range(0, 31) == 0));
    end
    drain(6);
    chk("final_level", 32'(level), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
